// File: rtl/regfile_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_arbiter_if
// Purpose  : Bundles the requester, register-file and response signals of the
//            shared register-file read port into one interface.
// Ports    : req/req_addr/stall     requester side, into the arbiter
//            gnt                    one-hot grant pulse back to requesters
//            rf_addr/rf_data        register-file read mux select and data
//            resp_valid/id/data     tagged read response
// Modports : master - environment (requesters + register file)
//            slave  - the arbiter itself
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [AW*NREQ-1:0] req_addr;
  logic               stall;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rf_addr;
  logic [DW-1:0]      rf_data;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [DW-1:0]      resp_data;

  modport master (
    output req, req_addr, stall, rf_data,
    input  gnt, rf_addr, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req, req_addr, stall, rf_data,
    output gnt, rf_addr, resp_valid, resp_id, resp_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_arbiter
// Purpose  : Shares the single register-file read port between NREQ
//            requesters. Arbitrates at each edge, registers the winner's
//            address onto the read-mux select, captures the mux output one
//            cycle later and returns it tagged with the requester ID.
// Ports    : clk      system clock, rising edge
//            reset_n  asynchronous active-low reset
//            bus      regfile_read_arbiter_if.slave (req, req_addr, stall,
//                     gnt, rf_addr, rf_data, resp_valid, resp_id, resp_data)
// Options  : RFARB_FIXED_PRIO_EN - when defined, fixed priority (lowest index
//            wins) replaces round-robin and the last-winner pointer is
//            removed. Undefined (default): round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  wire                     clk,
  input  wire                     reset_n,
  regfile_read_arbiter_if.slave   bus
);

  // Parameter sanity: the ID field has to be able to name every requester.
  if ((NREQ < 2) || (NREQ > 8) || ((1 << IDW) < NREQ)) begin : g_bad_param
    $error("regfile_read_arbiter: illegal NREQ/IDW combination");
  end

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [NREQ-1:0] r_gnt;
  logic [AW-1:0]   r_rf_addr;
  logic            r_pend;       // a grant was issued last edge, capture now
  logic [IDW-1:0]  r_pend_id;
  logic            r_resp_valid;
  logic [IDW-1:0]  r_resp_id;
  logic [DW-1:0]   r_resp_data;
`ifndef RFARB_FIXED_PRIO_EN
  logic [IDW-1:0]  r_last;       // index of the most recent winner
`endif

  // --------------------------------------------------------------------------
  // Unpack the per-requester addresses
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_addr_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_arr[g] = bus.req_addr[AW*g +: AW];
  end

  // A requester holding gnt this cycle sits out this edge, which gives every
  // requester at most one grant per two cycles.
  logic [NREQ-1:0] w_elig;
  assign w_elig = bus.req & ~r_gnt;

  // --------------------------------------------------------------------------
  // Winner selection
  // The lowest eligible index is always computed; round-robin additionally
  // looks for the lowest eligible index strictly above the last winner and
  // prefers it, which is the same as searching from last+1 with wrap-around.
  // --------------------------------------------------------------------------
  logic           w_lo_found;
  logic [IDW-1:0] w_lo_id;
  logic           w_win_valid;
  logic [IDW-1:0] w_win_id;
`ifndef RFARB_FIXED_PRIO_EN
  logic           w_hi_found;
  logic [IDW-1:0] w_hi_id;
`endif

  always_comb begin : arbitrate
    w_lo_found = 1'b0;
    w_lo_id    = '0;
`ifndef RFARB_FIXED_PRIO_EN
    w_hi_found = 1'b0;
    w_hi_id    = '0;
`endif
    // Descending scan: the last hit written is the lowest index.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_found = 1'b1;
        w_lo_id    = IDW'(i);
`ifndef RFARB_FIXED_PRIO_EN
        if (i > int'(r_last)) begin
          w_hi_found = 1'b1;
          w_hi_id    = IDW'(i);
        end
`endif
      end
    end
  end

`ifdef RFARB_FIXED_PRIO_EN
  assign w_win_valid = w_lo_found;
  assign w_win_id    = w_lo_id;
`else
  assign w_win_valid = w_lo_found;
  assign w_win_id    = w_hi_found ? w_hi_id : w_lo_id;
`endif

  // stall suppresses new grants only; the capture pipeline keeps running.
  logic w_grant;
  assign w_grant = w_win_valid & ~bus.stall;

  logic [NREQ-1:0] w_onehot;
  assign w_onehot = NREQ'(1) << w_win_id;

  logic [AW-1:0] w_win_addr;

  always_comb begin : addr_mux
    w_win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_id == IDW'(i)) begin
        w_win_addr = w_addr_arr[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Grant / select / capture pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt        <= '0;
      r_rf_addr    <= '0;
      r_pend       <= 1'b0;
      r_pend_id    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
`ifndef RFARB_FIXED_PRIO_EN
      r_last       <= IDW'(NREQ - 1);  // requester 0 first after reset
`endif
    end else begin
      // Stage 2: rf_data reflects the select registered on the previous edge.
      r_resp_valid <= r_pend;
      if (r_pend) begin
        r_resp_data <= bus.rf_data;
        r_resp_id   <= r_pend_id;
      end

      // Stage 1: issue a grant. rf_addr only moves on a grant so the read
      // mux select does not toggle while idle.
      r_pend <= w_grant;
      if (w_grant) begin
        r_gnt     <= w_onehot;
        r_rf_addr <= w_win_addr;
        r_pend_id <= w_win_id;
`ifndef RFARB_FIXED_PRIO_EN
        r_last    <= w_win_id;
`endif
      end else begin
        r_gnt <= '0;
      end
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_arbiter
// Purpose  : Self-checking bench for regfile_read_arbiter. A transaction
//            level reference model (grant search by modulo rotation, a
//            pending-read record and a register-file array) predicts every
//            output each cycle; directed scenarios add fixed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_read_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .AW(AW), .DW(DW)) bus ();

  regfile_read_arbiter #(.NREQ(NREQ), .IDW(IDW), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Register file contents; the read mux is combinational on rf_addr.
  logic [DW-1:0] regs [32];
  assign bus.rf_data = regs[bus.rf_addr];

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: state of the transaction in flight and the response
  // -------------------------------------------------------------------------
  logic [NREQ-1:0] m_gnt;
  int              m_last;
  bit              m_pend;
  int              m_pend_id;
  int              m_pend_reg;
  bit              m_rv;
  int              m_rid;
  logic [DW-1:0]   m_rdata;
  int              m_rf_addr;

  task automatic model_reset();
    m_gnt      = '0;
    m_last     = NREQ - 1;
    m_pend     = 0;
    m_pend_id  = 0;
    m_pend_reg = 0;
    m_rv       = 0;
    m_rid      = 0;
    m_rdata    = '0;
    m_rf_addr  = 0;
  endtask

  // One rising edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic [NREQ-1:0] elig;
    int win;
    elig = bus.req & ~m_gnt;
    win  = -1;
`ifdef RFARB_FIXED_PRIO_EN
    for (int c = 0; c < NREQ; c++)
      if (win < 0 && elig[c]) win = c;
`else
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_last + k) % NREQ;
      if (win < 0 && elig[c]) win = c;
    end
`endif
    if (bus.stall) win = -1;

    m_rv = m_pend;
    if (m_pend) begin
      m_rid   = m_pend_id;
      m_rdata = regs[m_pend_reg];
    end

    if (win >= 0) begin
      m_gnt      = NREQ'(1) << win;
      m_rf_addr  = int'(bus.req_addr[win*AW +: AW]);
      m_last     = win;
      m_pend     = 1;
      m_pend_id  = win;
      m_pend_reg = m_rf_addr;
    end else begin
      m_gnt  = '0;
      m_pend = 0;
    end
  endtask

  task automatic check_outputs();
    check_val("gnt",        32'(bus.gnt),        32'(m_gnt));
    check_val("rf_addr",    32'(bus.rf_addr),    32'(m_rf_addr));
    check_val("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
    check_val("resp_id",    32'(bus.resp_id),    32'(m_rid));
    check_val("resp_data",  bus.resp_data,       m_rdata);
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic s);
    bus.req   = r;
    bus.stall = s;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_addr(input int idx, input logic [AW-1:0] a);
    bus.req_addr[idx*AW +: AW] = a;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] rnd;
    int exp_ord [5];

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = '0;
    regs[7] = 32'h12345678;
    regs[9] = 32'hDEADBEEF;

    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.stall    = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // All four requesting from reset: rotation order.
`ifdef RFARB_FIXED_PRIO_EN
    exp_ord = '{0, 1, 0, 1, 0};
`else
    exp_ord = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < NREQ; i++) set_addr(i, AW'(i + 3));
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0);
      check_val("rotation", 32'(bus.gnt), 32'(1) << exp_ord[i]);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Single read from requester 2 at register 7.
    set_addr(2, 5'd7);
    step(4'b0100, 1'b0);
    check_val("single_gnt",  32'(bus.gnt), 32'h4);
    check_val("single_addr", 32'(bus.rf_addr), 32'd7);
    step(4'b0000, 1'b0);
    check_val("single_rv",   32'(bus.resp_valid), 32'd1);
    check_val("single_id",   32'(bus.resp_id), 32'd2);
    check_val("single_data", bus.resp_data, 32'h12345678);
    step(4'b0000, 1'b0);

    // Address 0 returns zero.
    set_addr(0, 5'd0);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    check_val("addr0_data", bus.resp_data, 32'h0);

    // Single requester holding req: grant every other cycle.
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 1'b0);
      check_val("hold_gnt", 32'(bus.gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Stall with a read already in flight, then release.
    step(4'b0010, 1'b0);
    check_val("pre_stall_gnt", 32'(bus.gnt), 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 1'b1);
      check_val("stall_gnt", 32'(bus.gnt), 32'h0);
      if (i == 0) check_val("stall_inflight_rv", 32'(bus.resp_valid), 32'd1);
    end
    step(4'b1010, 1'b0);
`ifdef RFARB_FIXED_PRIO_EN
    check_val("post_stall_gnt", 32'(bus.gnt), 32'h2);
`else
    check_val("post_stall_gnt", 32'(bus.gnt), 32'h8);
`endif
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

`ifdef RFARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      step(4'b0110, 1'b0);
      check_val("fixed_0110", 32'(bus.gnt), (i % 2 == 0) ? 32'h2 : 32'h4);
    end
    step(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'b0111, 1'b0);
      check_val("fixed_0111", 32'(bus.gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
`endif

    // Reset while a read is in flight to DEADBEEF.
    set_addr(1, 5'd9);
    step(4'b0010, 1'b0);
    check_val("flight_gnt", 32'(bus.gnt), 32'h2);
    #1 reset_n = 1'b0;
    bus.req = '0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1 check_outputs();
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0);
      check_val("post_reset_rv", 32'(bus.resp_valid), 32'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      bus.req_addr = rnd[AW*NREQ-1:0];
      rnd = $urandom;
      step(rnd[NREQ-1:0], ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
